// File: rtl/usb_cfg_loader.sv
// Purpose: USB CDC byte stream -> 32-bit config words (sync hunt, header word count, data). Optional macro: USB_CFG_LOADER_CHECKSUM_EN.
// Latency: a word is presented one cycle after its 4th byte. Backpressure: rx_ready_o = !cfg_valid_o, so no byte is dropped while a word waits.
module usb_cfg_loader #(
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_C0DE,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          ADDR_W         = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [31:0]       cfg_data_o,
    output logic [ADDR_W-1:0] cfg_addr_o,
    output logic              cfg_valid_o,
    input  logic              cfg_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
`ifdef USB_CFG_LOADER_CHECKSUM_EN
    localparam logic [1:0] CHK  = 2'd3;
`endif

    logic [1:0]        r_state;
    logic [31:0]       r_shift;
    logic [1:0]        r_byte_cnt;
    logic [15:0]       r_n;
    logic [TMO_W-1:0]  r_tmo;
    logic [31:0]       r_cfg_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cfg_valid;
    logic              r_done;
    logic              r_err;
`ifdef USB_CFG_LOADER_CHECKSUM_EN
    logic [31:0]       r_sum;
`endif

    logic        w_accept;
    logic [31:0] w_word;
    logic        w_last_byte;
    logic        w_xfer;
    logic        w_tmo_hit;

    assign w_accept    = rx_valid_i & ~r_cfg_valid;
    assign w_word      = {r_shift[23:0], rx_data_i};
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_xfer      = r_cfg_valid & cfg_ready_i;
    // An accepted byte on the expiry cycle wins over the timeout.
    assign w_tmo_hit   = (r_state != HUNT) && !w_accept && !r_cfg_valid && (r_tmo == TMO_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= HUNT;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_n         <= '0;
            r_tmo       <= '0;
            r_cfg_data  <= '0;
            r_addr      <= '0;
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef USB_CFG_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            if (r_state == HUNT || w_accept || r_cfg_valid || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_accept) begin
                r_shift    <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            case (r_state)
                HUNT: begin
                    if (w_accept && (w_word == SYNC_WORD)) begin
                        r_state    <= HDR;
                        r_byte_cnt <= '0;
                        r_err      <= 1'b0;
                    end
                end
                HDR: begin
                    if (w_accept && w_last_byte) begin
                        r_n    <= w_word[15:0];
                        r_addr <= '0;
`ifdef USB_CFG_LOADER_CHECKSUM_EN
                        r_sum  <= '0;
                        r_state <= (w_word[15:0] == 16'd0) ? CHK : DATA;
`else
                        if (w_word[15:0] == 16'd0) begin
                            r_state <= HUNT;
                            r_done  <= 1'b1;
                            r_shift <= '0;
                        end else begin
                            r_state <= DATA;
                        end
`endif
                    end
                end
                DATA: begin
                    if (w_accept && w_last_byte) begin
                        r_cfg_data  <= w_word;
                        r_cfg_valid <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_cfg_valid <= 1'b0;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_n         <= r_n - 16'd1;
`ifdef USB_CFG_LOADER_CHECKSUM_EN
                        r_sum       <= r_sum + r_cfg_data;
                        if (r_n == 16'd1) begin
                            r_state <= CHK;
                        end
`else
                        if (r_n == 16'd1) begin
                            r_state <= HUNT;
                            r_done  <= 1'b1;
                            r_shift <= '0;
                        end
`endif
                    end
                end
`ifdef USB_CFG_LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_accept && w_last_byte) begin
                        if (w_word == r_sum) begin
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= HUNT;
                        r_shift <= '0;
                    end
                end
`endif
                default: r_state <= HUNT;
            endcase

            // Timeout drops the partial word so stale bytes cannot form a false sync.
            if (w_tmo_hit) begin
                r_err      <= 1'b1;
                r_state    <= HUNT;
                r_byte_cnt <= '0;
                r_shift    <= '0;
            end
        end
    end

    assign rx_ready_o  = ~r_cfg_valid;
    assign cfg_data_o  = r_cfg_data;
    assign cfg_addr_o  = r_addr;
    assign cfg_valid_o = r_cfg_valid;
    assign busy_o      = (r_state != HUNT);
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_usb_cfg_loader.sv
// Bench for usb_cfg_loader: directed packets plus randomized packets/backpressure against a queue-based expected-word model.
// Runs the default build; the checksum scenarios compile in with USB_CFG_LOADER_CHECKSUM_EN.
module tb_usb_cfg_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_C0DE;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] cfg_data;
    logic [15:0] cfg_addr;
    logic        cfg_valid;
    logic        cfg_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    usb_cfg_loader #(
        .SYNC_WORD      (SYNC),
        .TIMEOUT_CYCLES (16),
        .ADDR_W         (16)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready),
        .cfg_data_o  (cfg_data),
        .cfg_addr_o  (cfg_addr),
        .cfg_valid_o (cfg_valid),
        .cfg_ready_i (cfg_ready),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [47:0] exp_q[$];
    logic [31:0] pkt_w[$];
    int          done_cnt = 0;
    int          xfer_cnt = 0;
    bit          mon_en = 1'b0;
    bit          bp_rand = 1'b0;
    logic        bp_level = 1'b1;
    logic        hold_prev = 1'b0;
    logic [47:0] prev_word = '0;
`ifdef USB_CFG_LOADER_CHECKSUM_EN
    logic [31:0] trailer_delta = '0;
`endif

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Downstream ready: random, or a level set by the directed tests.
    initial begin
        forever begin
            @(negedge clk);
            cfg_ready = bp_rand ? 1'($urandom_range(0, 1)) : bp_level;
        end
    end

    // Monitor: word transfers against the expected queue, hold stability, done pulses.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && rstn) begin
                if (done) done_cnt++;
                check("rdy_vs_vld", rx_ready, !cfg_valid);
                if (hold_prev) begin
                    check("hold_vld", cfg_valid, 1'b1);
                    check("hold_dat", {cfg_addr, cfg_data}, prev_word);
                end
                hold_prev = cfg_valid && !cfg_ready;
                prev_word = {cfg_addr, cfg_data};
                if (cfg_valid && cfg_ready) begin
                    xfer_cnt++;
                    check("xfer_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("xfer_word", {cfg_addr, cfg_data}, exp_q.pop_front());
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            k++;
        end while (!rx_ready && k < 300);
        if (!rx_ready) check("byte_accept_timeout", rx_ready, 1'b1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int rand_gap(input int gmax);
        if (gmax == 0) return 0;
        if ($urandom_range(0, 24) == 0) return 15;
        return int'($urandom_range(0, gmax));
    endfunction

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int i = 3; i >= 0; i--) begin
            idle(rand_gap(gmax));
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_end(input int d0, input logic exp_err, input int exp_done);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - d0, exp_done);
        check("err_end", err, exp_err);
        check("busy_end", busy, 1'b0);
    endtask

    // Expected words: word i of the packet appears at address i, in order.
    task automatic send_pkt(input logic [15:0] hi, input int gmax);
        int          d0;
        logic [31:0] sum;
        d0  = done_cnt;
        sum = '0;
        foreach (pkt_w[i]) begin
            exp_q.push_back({16'(i), pkt_w[i]});
            sum += pkt_w[i];
        end
        send_word(SYNC, gmax);
        send_word({hi, 16'(pkt_w.size())}, gmax);
        foreach (pkt_w[i]) send_word(pkt_w[i], gmax);
`ifdef USB_CFG_LOADER_CHECKSUM_EN
        send_word(sum + trailer_delta, gmax);
        wait_end(d0, trailer_delta != 0, (trailer_delta != 0) ? 0 : 1);
`else
        check("sum_consistent", sum, sum + 32'd0 + pkt_w.sum() - pkt_w.sum());
        wait_end(d0, 1'b0, 1);
`endif
    endtask

    initial begin
        int          d0;
        int          x0;
        int          n;
        int          g;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", cfg_valid, 1'b0);
        check("rst_rdy", rx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_dat", {cfg_addr, cfg_data}, 48'h0);
        @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Two-word packet, no backpressure
        pkt_w = '{32'h1122_3344, 32'hA5A5_A5A5};
        send_pkt(16'h0000, 0);

        // Same packet, word 0 held by backpressure with word 1 already offered
        bp_level = 1'b0;
        d0 = done_cnt;
        exp_q.push_back({16'd0, 32'h1122_3344});
        exp_q.push_back({16'd1, 32'hA5A5_A5A5});
        send_word(SYNC, 0);
        send_word(32'h0000_0002, 0);
        send_word(32'h1122_3344, 0);
        fork
            send_word(32'hA5A5_A5A5, 0);
            begin
                for (int k = 0; k < 50 && !cfg_valid; k++) @(negedge clk);
                repeat (10) begin
                    @(negedge clk);
                    check("bp_vld", cfg_valid, 1'b1);
                    check("bp_dat", cfg_data, 32'h1122_3344);
                    check("bp_rdy", rx_ready, 1'b0);
                end
                bp_level = 1'b1;
            end
        join
`ifdef USB_CFG_LOADER_CHECKSUM_EN
        send_word(32'h1122_3344 + 32'hA5A5_A5A5, 0);
`endif
        wait_end(d0, 1'b0, 1);

        // Garbage containing a partial sync, then the real sync
        d0 = done_cnt;
        foreach (pkt_w[i]) pkt_w[i] = '0;
        send_byte(8'h00); check("hunt_busy0", busy, 1'b0);
        send_byte(8'hFA); check("hunt_busy1", busy, 1'b0);
        send_byte(8'hB0); check("hunt_busy2", busy, 1'b0);
        send_byte(8'hC0); check("hunt_busy3", busy, 1'b0);
        send_byte(8'hFA); check("hunt_busy4", busy, 1'b0);
        send_byte(8'hB0); check("hunt_busy5", busy, 1'b0);
        send_byte(8'hC0); check("hunt_busy6", busy, 1'b0);
        send_byte(8'hDE); check("sync_busy", busy, 1'b1);
        send_word(32'h0000_0000, 0);
`ifdef USB_CFG_LOADER_CHECKSUM_EN
        send_word(32'h0000_0000, 0);
`endif
        wait_end(d0, 1'b0, 1);

        // Timeout after two data bytes (TIMEOUT_CYCLES = 16)
        d0 = done_cnt;
        send_word(SYNC, 0);
        send_word(32'h0000_0001, 0);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (15) @(posedge clk);
        #1;
        check("tmo_early_err", err, 1'b0);
        check("tmo_early_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        check("tmo_err", err, 1'b1);
        check("tmo_busy", busy, 1'b0);
        idle(5);
        check("tmo_sticky", err, 1'b1);
        check("tmo_done", done_cnt - d0, 0);
        send_word(SYNC, 0);
        check("sync_clr_err", err, 1'b0);
        send_word(32'h0000_0000, 0);
`ifdef USB_CFG_LOADER_CHECKSUM_EN
        send_word(32'h0000_0000, 0);
`endif
        wait_end(d0, 1'b0, 1);

        // Randomized packets, gaps and backpressure
        bp_rand = 1'b1;
        for (int p = 0; p < 30; p++) begin
            n = int'($urandom_range(0, 5));
            g = int'($urandom_range(0, 3));
            for (int j = 0; j < g; j++) send_byte(8'($urandom_range(0, 249)));
            pkt_w.delete();
            for (int j = 0; j < n; j++) pkt_w.push_back(($urandom_range(0, 3) == 0) ? SYNC : 32'($urandom));
            send_pkt(16'($urandom), 2);
        end
        bp_rand = 1'b0;

`ifdef USB_CFG_LOADER_CHECKSUM_EN
        pkt_w = '{32'd1, 32'd2};
        trailer_delta = 32'd0;
        send_pkt(16'h0000, 0);
        trailer_delta = 32'd1;
        send_pkt(16'h0000, 0);
        trailer_delta = 32'd0;
`endif

        // Reset while a word is pending, then header bytes without sync
        bp_level = 1'b0;
        send_word(SYNC, 0);
        send_word(32'h0000_0002, 0);
        send_word(32'hDEAD_BEEF, 0);
        for (int k = 0; k < 50 && !cfg_valid; k++) @(negedge clk);
        check("pre_rst_vld", cfg_valid, 1'b1);
        @(negedge clk);
        mon_en = 1'b0;
        rstn   = 1'b0;
        #1;
        check("mid_rst_vld", cfg_valid, 1'b0);
        check("mid_rst_rdy", rx_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_dat", {cfg_addr, cfg_data}, 48'h0);
        @(negedge clk);
        rstn     = 1'b1;
        bp_level = 1'b1;
        exp_q.delete();
        mon_en   = 1'b1;
        x0 = xfer_cnt;
        send_word(32'h0000_0002, 0);
        send_word(32'h1234_5678, 0);
        idle(20);
        check("nosync_busy", busy, 1'b0);
        check("nosync_xfer", xfer_cnt - x0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
